// File: rtl/ir_queue.sv
// ir_queue: instruction register queue for the LC-3b datapath.
//
// Buffers up to DEPTH fetched instruction words in FIFO order. The control
// unit sees the oldest entry as head_word plus its decoded fields. Fetch
// writes words with a valid/ready handshake. Control consumes the head with
// a deq strobe. flush discards everything on a redirect.
//
// Optional feature macro: IR_QUEUE_BYPASS_EN
//   When defined, a word offered to an empty queue is presented on the head
//   outputs in the same cycle. If deq is also high in that cycle, the word is
//   consumed there and is never written to storage.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset, clears the queue
//   in_valid       fetch presents in_data
//   in_data        instruction word (WIDTH bits)
//   in_ready       queue can accept a word this cycle (count < DEPTH)
//   deq            consume the head entry
//   flush          discard all entries; has priority over push and pop
//   head_valid     head entry present, decoded fields meaningful
//   head_word      raw head word (0 when empty)
//   count          occupancy
//   opcode         head[15:12]
//   dest/src1/src2 head[11:9] / head[8:6] / head[2:0]
//   offset11/9/6   head[10:0] / head[8:0] / head[5:0]
//   imm5/imm4      head[4:0] / head[3:0]
//   instruction4/5/11  head bits 4 / 5 / 11

package lc3b_types;
  typedef logic [3:0] lc3b_opcode;
  typedef logic [2:0] lc3b_reg;
endpackage

module ir_queue
  import lc3b_types::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       deq,
  input  logic                       flush,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_word,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output lc3b_opcode                 opcode,
  output lc3b_reg                    dest,
  output lc3b_reg                    src1,
  output lc3b_reg                    src2,
  output logic [10:0]                offset11,
  output logic [8:0]                 offset9,
  output logic [5:0]                 offset6,
  output logic [4:0]                 imm5,
  output logic [3:0]                 imm4,
  output logic                       instruction4,
  output logic                       instruction5,
  output logic                       instruction11
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;

  logic empty;
  logic bypass_hit;
  logic push_en;
  logic pop_en;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q != FULL_COUNT);
  assign count    = count_q;

`ifdef IR_QUEUE_BYPASS_EN
  assign bypass_hit = empty && in_valid && !flush;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed word that is dequeued in the same cycle never touches storage.
  // Pops only come from storage. The bypass case above covers the empty queue.
  assign push_en = in_valid && in_ready && !flush && !(bypass_hit && deq);
  assign pop_en  = deq && !empty && !flush;

  always_comb begin
    head_valid = !empty || bypass_hit;
    head_word  = '0;
    if (!empty) begin
      head_word = mem[rd_ptr];
    end else if (bypass_hit) begin
      head_word = in_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset. Nothing reads an empty slot, because empty head
  // outputs are forced to 0.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  assign opcode        = head_word[15:12];
  assign dest          = head_word[11:9];
  assign src1          = head_word[8:6];
  assign src2          = head_word[2:0];
  assign offset11      = head_word[10:0];
  assign offset9       = head_word[8:0];
  assign offset6       = head_word[5:0];
  assign imm5          = head_word[4:0];
  assign imm4          = head_word[3:0];
  assign instruction4  = head_word[4];
  assign instruction5  = head_word[5];
  assign instruction11 = head_word[11];

endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: directed testbench for ir_queue with DEPTH=4, WIDTH=16.
// Expected values are hand-computed from the instruction encodings.

module tb_ir_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        deq;
  logic        flush;
  logic        head_valid;
  logic [15:0] head_word;
  logic [2:0]  count;
  logic [3:0]  opcode;
  logic [2:0]  dest;
  logic [2:0]  src1;
  logic [2:0]  src2;
  logic [10:0] offset11;
  logic [8:0]  offset9;
  logic [5:0]  offset6;
  logic [4:0]  imm5;
  logic [3:0]  imm4;
  logic        instruction4;
  logic        instruction5;
  logic        instruction11;

  int testsRun;
  int testsFailed;

  ir_queue #(.DEPTH(4), .WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .deq          (deq),
    .flush        (flush),
    .head_valid   (head_valid),
    .head_word    (head_word),
    .count        (count),
    .opcode       (opcode),
    .dest         (dest),
    .src1         (src1),
    .src2         (src2),
    .offset11     (offset11),
    .offset9      (offset9),
    .offset6      (offset6),
    .imm5         (imm5),
    .imm4         (imm4),
    .instruction4 (instruction4),
    .instruction5 (instruction5),
    .instruction11(instruction11)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives all control inputs.
  task automatic applyStimulus(input logic v, input logic [15:0] d,
                               input logic dq, input logic fl);
    in_valid = v;
    in_data  = d;
    deq      = dq;
    flush    = fl;
  endtask

  // Advances to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] fillWords [4];

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    fillWords[0] = 16'h1283;
    fillWords[1] = 16'h5AA5;
    fillWords[2] = 16'h0E3F;
    fillWords[3] = 16'hC1C0;

    reset = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    #12;
    reset = 1'b0;
    tick();

    // Idle queue after reset.
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_head_valid", 32'(head_valid), 32'd0);
    checkOutput("reset_opcode", 32'(opcode), 32'd0);
    checkOutput("reset_dest", 32'(dest), 32'd0);
    checkOutput("reset_head_word", 32'(head_word), 32'd0);

    // Fill to DEPTH with back-to-back pushes.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fillWords[i], 1'b0, 1'b0);
      tick();
      if (i == 0) begin
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        checkOutput("first_head_valid", 32'(head_valid), 32'd1);
        checkOutput("first_opcode", 32'(opcode), 32'h1);
        checkOutput("first_dest", 32'(dest), 32'd1);
        checkOutput("first_src1", 32'(src1), 32'd2);
        checkOutput("first_src2", 32'(src2), 32'd3);
        checkOutput("first_instr5", 32'(instruction5), 32'd0);
      end
    end
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);

    // A push into the full queue is refused.
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0);
    tick();
    checkOutput("refused_count", 32'(count), 32'd4);
    checkOutput("refused_head", 32'(head_word), 32'h1283);

    // There is no pass-through: with deq high at full, the push is still refused.
    applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    checkOutput("pop1_count", 32'(count), 32'd3);
    checkOutput("pop1_in_ready", 32'(in_ready), 32'd1);
    checkOutput("pop1_head", 32'(head_word), 32'h5AA5);
    checkOutput("5aa5_opcode", 32'(opcode), 32'h5);
    checkOutput("5aa5_dest", 32'(dest), 32'd5);
    checkOutput("5aa5_offset11", 32'(offset11), 32'h2A5);
    checkOutput("5aa5_offset9", 32'(offset9), 32'h0A5);
    checkOutput("5aa5_offset6", 32'(offset6), 32'h25);
    checkOutput("5aa5_imm5", 32'(imm5), 32'h05);
    checkOutput("5aa5_imm4", 32'(imm4), 32'h5);
    checkOutput("5aa5_instr4", 32'(instruction4), 32'd0);
    checkOutput("5aa5_instr5", 32'(instruction5), 32'd1);
    checkOutput("5aa5_instr11", 32'(instruction11), 32'd1);

    // Drain the remaining entries in order; 16'hFFFF must not appear.
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      #1;
      checkOutput($sformatf("drain_head%0d", i), 32'(head_word), 32'(fillWords[i]));
      tick();
    end
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    checkOutput("drained_count", 32'(count), 32'd0);
    checkOutput("drained_head_valid", 32'(head_valid), 32'd0);
    checkOutput("drained_head_word", 32'(head_word), 32'd0);

    // An extra deq while empty is ignored.
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    checkOutput("empty_deq_count", 32'(count), 32'd0);

    // Steady state at count=2 with simultaneous push and pop.
    applyStimulus(1'b1, 16'h1000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h1001, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 16'(16'h1002 + i), 1'b1, 1'b0);
      #1;
      checkOutput($sformatf("steady_head%0d", i), 32'(head_word), 32'(16'h1000 + i));
      checkOutput($sformatf("steady_count%0d", i), 32'(count), 32'd2);
      tick();
    end
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    #1;
    checkOutput("steady_tail0", 32'(head_word), 32'h100A);
    tick();
    #1;
    checkOutput("steady_tail1", 32'(head_word), 32'h100B);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

    // Fill to 3, then flush while pushing and dequeuing.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'(16'h4000 + i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 16'h2000, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_head_valid", 32'(head_valid), 32'd0);
    checkOutput("flush_head_word", 32'(head_word), 32'd0);
    applyStimulus(1'b1, 16'h3001, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    checkOutput("post_flush_valid", 32'(head_valid), 32'd1);
    checkOutput("post_flush_head", 32'(head_word), 32'h3001);
    checkOutput("post_flush_count", 32'(count), 32'd1);

    // Asynchronous reset between edges with count=3.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 16'(16'h7000 + i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    checkOutput("pre_areset_count", 32'(count), 32'd3);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("areset_count", 32'(count), 32'd0);
    checkOutput("areset_head_valid", 32'(head_valid), 32'd0);
    checkOutput("areset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("areset_head_word", 32'(head_word), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Empty queue with in_valid and deq both high in the same cycle.
    applyStimulus(1'b1, 16'h0E05, 1'b1, 1'b0);
    #1;
`ifdef IR_QUEUE_BYPASS_EN
    checkOutput("bypass_head_valid", 32'(head_valid), 32'd1);
    checkOutput("bypass_opcode", 32'(opcode), 32'h0);
    checkOutput("bypass_offset9", 32'(offset9), 32'h005);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    checkOutput("bypass_count", 32'(count), 32'd0);
`else
    checkOutput("nobypass_head_valid", 32'(head_valid), 32'd0);
    checkOutput("nobypass_head_word", 32'(head_word), 32'd0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    checkOutput("nobypass_count", 32'(count), 32'd1);
    checkOutput("nobypass_head", 32'(head_word), 32'h0E05);
    checkOutput("nobypass_offset9", 32'(offset9), 32'h005);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register queue for the LC-3b datapath. It buffers up to DEPTH fetched instruction words in FIFO order and presents the decoded fields of the oldest entry to the control unit. Fetch writes words with a valid/ready handshake, and control consumes them with a dequeue strobe. A flush input discards all buffered instructions on a redirect.

## Interface
- DEPTH, 4, number of instruction entries; power of two, at least 2.
- WIDTH, 16, instruction word width; must be at least 16, with fields decoded from bits [15:0].
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears the queue.
- in_valid  in  1  fetch presents a word.
- in_data  in  WIDTH  instruction word.
- in_ready  out  1  queue accepts a word this cycle.
- deq  in  1  consume the head entry.
- flush  in  1  discard all entries.
- head_valid  out  1  head entry present; decoded fields are meaningful.
- head_word  out  WIDTH  raw head word.
- count  out  $clog2(DEPTH+1)  occupancy.
- opcode  out  lc3b_opcode  head [15:12].
- dest / src1 / src2  out  lc3b_reg each  head [11:9] / [8:6] / [2:0].
- offset11 / offset9 / offset6  out  11/9/6  head [10:0] / [8:0] / [5:0].
- imm5 / imm4  out  5/4  head [4:0] / [3:0].
- instruction4 / instruction5 / instruction11  out  1 each  head bits 4 / 5 / 11.

## Operation
- Storage is a circular buffer with read pointer rd_ptr, write pointer wr_ptr and count.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- in_ready = (count < DEPTH). There is no pass-through when full: a push to a full queue is refused even if deq is high.
- Push occurs when in_valid && in_ready && !flush.
  - Writes mem[wr_ptr]; wr_ptr increments.
- Pop occurs when deq && head_valid && !flush.
  - rd_ptr increments.
  - deq while empty is ignored; count stays 0.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- flush has priority over push and pop.
  - Next cycle: count=0, rd_ptr=wr_ptr=0.
  - A word presented with flush is dropped.
- Empty-queue outputs: head_valid=0, and head_word plus every decoded field drive 0 (decode of 16'h0000), never stale memory.
- Decoded fields are pure combinational slices of head_word; sign extension happens downstream.

## Timing
- Reset (async assert, sync-safe release) gives count=0, pointers 0, head_valid=0, in_ready=1, all fields 0.
- Reset mid-operation discards all contents immediately, without waiting for a clock edge.
- Write-to-head latency is 1 cycle.
  - A word pushed at edge N into an empty queue appears on head_valid/fields after edge N.
  - With bypass (see Configuration) the latency is 0 cycles.
- After a pop at edge N, the next entry is visible after edge N; there are no bubbles between back-to-back entries.
- in_ready and head_valid depend only on registered state (count), except head_valid under bypass.
- Full→pop: in_ready rises in the cycle after the popping edge.

## Configuration
- IR_QUEUE_BYPASS_EN, when defined:
  - If count==0 && in_valid && !flush, then head_valid=1 and head_word/fields reflect in_data combinationally.
  - If deq is also high that cycle, the word is consumed without being written: pointers and count are unchanged.
  - If deq is low, the word is written normally.
- When undefined: no combinational path from in_data/in_valid to any output; head outputs come from registered storage only.

## Test plan
- Reset, then idle: count=0, in_ready=1, head_valid=0, opcode=0, dest=0.
- DEPTH=4: push 16'h1283, 16'h5AA5, 16'h0E3F, 16'hC1C0 on consecutive cycles.
  - count reaches 4 and in_ready=0.
  - A fifth push with 16'hFFFF is refused.
  - Pops return the words in order; the first head gives opcode=4'h1, dest=1, src1=2, src2=3, instruction5=0.
- Steady state at count=2 with push and deq every cycle for 10 cycles: count stays 2, words exit in order, and the pointers wrap past 3→0 without corruption.
- Fill to 3, then assert flush together with in_valid (16'h2000) and deq.
  - Next cycle: count=0, head_valid=0.
  - A subsequent push of 16'h3001 becomes the head after 1 cycle.
- Assert reset asynchronously between edges with count=3: outputs clear before the next clk edge.
- With IR_QUEUE_BYPASS_EN and an empty queue, in_valid+deq with 16'h0E05: opcode=4'h0, offset9=9'h005 in the same cycle, and count remains 0. Without the macro, the same stimulus gives head_valid=0 that cycle and count=1 after the edge.
